led_row_shifter: RTL and testbench

LED_ROW_SHIFTER -- requirements
Module: led_row_shifter

---
 rtl/led_row_shifter_pkg.sv | 29 ++
 rtl/led_row_shifter_px_fetch.sv | 85 ++++++++
 rtl/led_row_shifter.sv | 151 +++++++++++++++
 tb/tb_led_row_shifter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_row_shifter_pkg.sv
// Shared types and constants for the TLC5955 row shifter: FSM states, frame
// geometry and the RGB565 to 3x16-bit channel expansion.
package led_row_shifter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SHIFT,
    LATCH,
    DONE
  } state_e;

  localparam int TLC5955_BITS = 769;
  localparam int CH_PER_CHIP  = 48;
  localparam int PX_PER_CHAIN = 16;
  localparam int WORD_W       = 16;

  // Returns {B16, G16, R16}; MSB of the result is the first bit on the wire.
  function automatic logic [CH_PER_CHIP-1:0] expand565(input logic [WORD_W-1:0] px);
    logic [15:0] r16;
    logic [15:0] g16;
    logic [15:0] b16;
    r16 = {px[15:11], px[15:11], px[15:11], px[15]};
    g16 = {px[10:5], px[10:5], px[10:7]};
    b16 = {px[4:0], px[4:0], px[4:0], px[4]};
    return {b16, g16, r16};
  endfunction

endpackage

// File: rtl/led_row_shifter_px_fetch.sv
// Fetches one pixel column (one word per chain) from the row buffer, aligning
// the read data to its issuing address and holding it in a staging array.
module led_px_fetch
  import led_row_shifter_pkg::*;
#(
  parameter int NUM_SHIFT  = 8,
  parameter int ROW_WORDS  = 128,
  parameter int RD_LATENCY = 2,
  parameter int AW         = $clog2(ROW_WORDS),
  parameter int PW         = $clog2(PX_PER_CHAIN)
) (
  input  logic                        spiClk,
  input  logic                        nReset,
  input  logic                        start_i,
  input  logic [PW-1:0]               pix_i,
  output logic [AW-1:0]               rdaddress_o,
  input  logic [WORD_W-1:0]           ledColBuf_i,
  output logic                        staged_o,
  output logic [NUM_SHIFT*WORD_W-1:0] stage_o
);

  localparam int CW = (NUM_SHIFT > 1) ? $clog2(NUM_SHIFT) : 1;

  logic              issue_q;
  logic [CW-1:0]     chain_q;
  logic [PW-1:0]     pix_q;
  logic [AW-1:0]     addr_q;
  logic              staged_q;
  logic [RD_LATENCY:0] vld_q;
  logic [CW-1:0]     idx_q [RD_LATENCY+1];
  logic [WORD_W-1:0] stage_q [NUM_SHIFT];

  logic          issue_now;
  logic [CW-1:0] issue_idx;
  logic [PW-1:0] issue_pix;

  assign issue_now = start_i | issue_q;
  assign issue_idx = start_i ? '0 : chain_q;
  assign issue_pix = start_i ? pix_i : pix_q;

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      issue_q  <= 1'b0;
      chain_q  <= '0;
      pix_q    <= '0;
      addr_q   <= '0;
      staged_q <= 1'b0;
      vld_q    <= '0;
    end else begin
      if (issue_now) begin
        addr_q <= AW'(int'(issue_idx) * PX_PER_CHAIN + int'(issue_pix));
      end
      if (start_i) begin
        pix_q   <= pix_i;
        chain_q <= CW'(1);
        issue_q <= (NUM_SHIFT > 1);
      end else if (issue_q) begin
        chain_q <= chain_q + CW'(1);
        if (chain_q == CW'(NUM_SHIFT-1)) issue_q <= 1'b0;
      end
      // vld_q[k]: the word addressed k cycles ago is on ledColBuf_i now.
      vld_q[0] <= issue_now;
      for (int k = 1; k <= RD_LATENCY; k++) vld_q[k] <= vld_q[k-1];
      if (start_i) begin
        staged_q <= 1'b0;
      end else if (vld_q[RD_LATENCY] && idx_q[RD_LATENCY] == CW'(NUM_SHIFT-1)) begin
        staged_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge spiClk) begin
    idx_q[0] <= issue_idx;
    for (int k = 1; k <= RD_LATENCY; k++) idx_q[k] <= idx_q[k-1];
    if (vld_q[RD_LATENCY]) stage_q[idx_q[RD_LATENCY]] <= ledColBuf_i;
  end

  always_comb begin
    for (int c = 0; c < NUM_SHIFT; c++) stage_o[c*WORD_W +: WORD_W] = stage_q[c];
  end

  assign rdaddress_o = addr_q;
  assign staged_o    = staged_q;

endmodule

// File: rtl/led_row_shifter.sv
// Shifts one buffered LED row into NUM_SHIFT parallel TLC5955 chains as a
// 769-bit grayscale frame per chain, then pulses LAT and reports completion.
module led_row_shifter
  import led_row_shifter_pkg::*;
#(
  parameter int NUM_SHIFT  = 8,
  parameter int ROW_WORDS  = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic                         spiClk,
  input  logic                         nReset,
  input  logic                         cmdStart,
  output logic                         cmdDone,
  output logic                         busy,
  output logic [$clog2(ROW_WORDS)-1:0] rdaddress,
  input  logic [WORD_W-1:0]            ledColBuf,
  output logic [NUM_SHIFT-1:0]         SDOs,
  output logic                         SCLK,
  output logic                         LAT
);

  localparam int PW = $clog2(PX_PER_CHAIN);
  localparam int BW = $clog2(CH_PER_CHIP);
  localparam int FW = $clog2(TLC5955_BITS);

  state_e                 state_q, state_d;
  logic                   phase_q;
  logic [FW-1:0]          bit_q;
  logic [PW-1:0]          pix_q;
  logic [BW-1:0]          pbit_q;
  logic                   lat_q;
  logic [CH_PER_CHIP-1:0] shift_q [NUM_SHIFT];

  logic                        staged;
  logic [NUM_SHIFT*WORD_W-1:0] stage;
  logic                        hdr, bit_end, px_end, load_px, fetch_go;
  logic [PW-1:0]               fetch_pix;

  assign hdr     = (bit_q == FW'(TLC5955_BITS-1));
  assign bit_end = (state_q == SHIFT) && phase_q;
  assign px_end  = bit_end && !hdr && (pbit_q == '0);
  assign load_px = ((state_q == PREFETCH) && staged) || (px_end && (pix_q != '0));

  // The next pixel is fetched while the current one shifts, so it is staged
  // well before the pixel boundary and SCLK never stalls.
  always_comb begin
    fetch_go  = 1'b0;
    fetch_pix = PW'(PX_PER_CHAIN-1);
    if ((state_q == IDLE) && cmdStart) begin
      fetch_go = 1'b1;
    end else if ((state_q == PREFETCH) && staged) begin
      fetch_go  = 1'b1;
      fetch_pix = PW'(PX_PER_CHAIN-2);
    end else if (px_end && (pix_q >= PW'(2))) begin
      fetch_go  = 1'b1;
      fetch_pix = pix_q - PW'(2);
    end
  end

  led_px_fetch #(
    .NUM_SHIFT (NUM_SHIFT),
    .ROW_WORDS (ROW_WORDS),
    .RD_LATENCY(RD_LATENCY)
  ) u_fetch (
    .spiClk     (spiClk),
    .nReset     (nReset),
    .start_i    (fetch_go),
    .pix_i      (fetch_pix),
    .rdaddress_o(rdaddress),
    .ledColBuf_i(ledColBuf),
    .staged_o   (staged),
    .stage_o    (stage)
  );

  always_ff @(posedge spiClk) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (cmdStart)                 state_d = PREFETCH;
      PREFETCH: if (staged)                   state_d = SHIFT;
      SHIFT:    if (bit_end && bit_q == '0)   state_d = LATCH;
      LATCH:    if (lat_q)                    state_d = DONE;
      DONE:                                   state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  always_ff @(posedge spiClk) begin
    if (!nReset) begin
      phase_q <= 1'b0;
      bit_q   <= '0;
      pix_q   <= '0;
      pbit_q  <= '0;
      lat_q   <= 1'b0;
    end else begin
      case (state_q)
        PREFETCH: begin
          phase_q <= 1'b0;
          bit_q   <= FW'(TLC5955_BITS-1);
          pix_q   <= PW'(PX_PER_CHAIN-1);
          pbit_q  <= BW'(CH_PER_CHIP-1);
          lat_q   <= 1'b0;
        end
        SHIFT: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            bit_q <= bit_q - FW'(1);
            if (!hdr) begin
              if (pbit_q != '0) begin
                pbit_q <= pbit_q - BW'(1);
              end else begin
                pix_q  <= pix_q - PW'(1);
                pbit_q <= BW'(CH_PER_CHIP-1);
              end
            end
          end
        end
        LATCH:   lat_q <= ~lat_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge spiClk) begin
    if (load_px) begin
      for (int c = 0; c < NUM_SHIFT; c++) shift_q[c] <= expand565(stage[c*WORD_W +: WORD_W]);
    end
  end

  always_comb begin
    SCLK    = 1'b0;
    LAT     = 1'b0;
    cmdDone = 1'b0;
    SDOs    = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      SHIFT: begin
        SCLK = phase_q;
        for (int c = 0; c < NUM_SHIFT; c++) SDOs[c] = hdr ? 1'b0 : shift_q[c][pbit_q];
      end
      LATCH:   LAT = 1'b1;
      DONE:    cmdDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_led_row_shifter.sv
// Directed bench for led_row_shifter with a 2-cycle-latency row buffer model.
module tb_led_row_shifter;

  localparam int NS  = 8;
  localparam int RW  = 128;
  localparam int RL  = 2;
  localparam int AW  = 7;
  localparam int FB  = 769;
  localparam int LATENCY = 1553;

  logic          spiClk = 1'b0;
  logic          nReset;
  logic          cmdStart;
  logic          cmdDone, busy, SCLK, LAT;
  logic [AW-1:0] rdaddress;
  logic [15:0]   ledColBuf;
  logic [NS-1:0] SDOs;

  logic [15:0] mem [RW];
  logic [15:0] rd1;
  int cyc = 0;

  int n_chk = 0;
  int n_fail = 0;

  logic [FB-1:0] fr [NS];
  logic [FB-1:0] exp_fr;
  int rises, gaps, sdo_viol, lat_cyc, lat_pulses, lat_sdo_err, dones, busy_breaks;
  int start_cyc, done_cyc, last_rise;
  logic prev_sclk, prev_lat;
  logic [NS-1:0] prev_sdo;

  led_row_shifter #(.NUM_SHIFT(NS), .ROW_WORDS(RW), .RD_LATENCY(RL)) dut (
    .spiClk   (spiClk),
    .nReset   (nReset),
    .cmdStart (cmdStart),
    .cmdDone  (cmdDone),
    .busy     (busy),
    .rdaddress(rdaddress),
    .ledColBuf(ledColBuf),
    .SDOs     (SDOs),
    .SCLK     (SCLK),
    .LAT      (LAT)
  );

  always #5 spiClk = ~spiClk;
  always @(posedge spiClk) cyc <= cyc + 1;
  always @(posedge spiClk) begin
    rd1       <= mem[rdaddress];
    ledColBuf <= rd1;
  end

  function automatic logic [47:0] tb_expand(input logic [15:0] w);
    logic [4:0] r5, b5;
    logic [5:0] g6;
    logic [15:0] r, g, b;
    r5 = w[15:11]; g6 = w[10:5]; b5 = w[4:0];
    for (int i = 0; i < 16; i++) begin
      r[15-i] = r5[4 - (i % 5)];
      g[15-i] = g6[5 - (i % 6)];
      b[15-i] = b5[4 - (i % 5)];
    end
    return {b, g, r};
  endfunction

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < RW; i++) mem[i] = v;
  endtask

  task automatic clear_stats();
    rises = 0; gaps = 0; sdo_viol = 0; lat_cyc = 0; lat_pulses = 0; lat_sdo_err = 0;
    dones = 0; busy_breaks = 0; done_cyc = 0; last_rise = 0;
    prev_sclk = 1'b0; prev_lat = 1'b0; prev_sdo = '0;
    for (int c = 0; c < NS; c++) fr[c] = '0;
  endtask

  task automatic sample();
    if (SCLK && !prev_sclk) begin
      if (rises > 0 && (cyc - last_rise) != 2) gaps++;
      last_rise = cyc;
      rises++;
      for (int c = 0; c < NS; c++) fr[c] = {fr[c][FB-2:0], SDOs[c]};
    end
    if (SCLK && SDOs !== prev_sdo) sdo_viol++;
    if (LAT) begin
      lat_cyc++;
      if (!prev_lat) lat_pulses++;
      if (SDOs != '0) lat_sdo_err++;
    end
    if (cmdDone) begin dones++; done_cyc = cyc; end
    prev_sclk = SCLK; prev_lat = LAT; prev_sdo = SDOs;
  endtask

  task automatic run_frame(input bit repulse);
    bit pulsed = 1'b0;
    clear_stats();
    @(posedge spiClk); #1 cmdStart = 1'b1; start_cyc = cyc;
    @(posedge spiClk); #1 cmdStart = 1'b0;
    for (int k = 0; k < 2000 && dones == 0; k++) begin
      @(negedge spiClk);
      cmdStart = 1'b0;
      if (!busy) busy_breaks++;
      sample();
      if (repulse && !pulsed && rises == 300 && !SCLK) begin cmdStart = 1'b1; pulsed = 1'b1; end
    end
    n_chk++;
    if (dones == 0) begin n_fail++; $display("FAIL frame_timeout: cmdDone count %0d required 1", dones); end
    @(negedge spiClk);
    cmdStart = 1'b0;
    n_chk++;
    if ({busy, SCLK, LAT, SDOs} !== '0) begin
      n_fail++; $display("FAIL idle_outputs: busy/SCLK/LAT/SDOs=%b required 0", {busy, SCLK, LAT, SDOs});
    end
    sample();
    for (int k = 0; k < 4; k++) begin @(negedge spiClk); sample(); end
  endtask

  task automatic check_common(input string tag);
    n_chk++;
    if (rises != FB) begin n_fail++; $display("FAIL %s_sclk_rises: got %0d required %0d", tag, rises, FB); end
    n_chk++;
    if (dones != 1) begin n_fail++; $display("FAIL %s_cmddone: got %0d required 1", tag, dones); end
    n_chk++;
    if (lat_pulses != 1 || lat_cyc != 2) begin
      n_fail++; $display("FAIL %s_lat: pulses %0d cycles %0d required 1 and 2", tag, lat_pulses, lat_cyc);
    end
    n_chk++;
    if (done_cyc - start_cyc + 1 != LATENCY) begin
      n_fail++; $display("FAIL %s_latency: got %0d required %0d", tag, done_cyc - start_cyc + 1, LATENCY);
    end
    n_chk++;
    if (gaps != 0 || sdo_viol != 0 || lat_sdo_err != 0 || busy_breaks != 0) begin
      n_fail++;
      $display("FAIL %s_timing: gaps %0d sdo_changes_sclk_high %0d sdo_in_latch %0d busy_drops %0d required all 0",
               tag, gaps, sdo_viol, lat_sdo_err, busy_breaks);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; cmdStart = 1'b0;
    fill(16'h0000);
    repeat (3) @(posedge spiClk);
    @(negedge spiClk);
    n_chk++;
    if ({busy, cmdDone, LAT, SCLK, SDOs} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", {busy, cmdDone, LAT, SCLK, SDOs});
    end
    n_chk++;
    if (rdaddress !== '0) begin n_fail++; $display("FAIL reset_rdaddress: got %0d required 0", rdaddress); end
    nReset = 1'b1;
  endtask

  task automatic test_all_ones();
    fill(16'hFFFF);
    run_frame(1'b0);
    check_common("ones");
    exp_fr = '1; exp_fr[FB-1] = 1'b0;
    for (int c = 0; c < NS; c++) begin
      n_chk++;
      if (fr[c] !== exp_fr) begin n_fail++; $display("FAIL ones_chain%0d: got %h required %h", c, fr[c], exp_fr); end
    end
    n_chk++;
    if (rdaddress !== 7'd112) begin n_fail++; $display("FAIL idle_rdaddress_hold: got %0d required 112", rdaddress); end
  endtask

  task automatic test_single_pixel();
    fill(16'h0000);
    mem[0] = 16'h8410;
    run_frame(1'b0);
    check_common("px8410");
    exp_fr = '0; exp_fr[47:0] = 48'h8421_8208_8421;
    n_chk++;
    if (fr[0] !== exp_fr) begin n_fail++; $display("FAIL px8410_chain0: got %h required %h", fr[0], exp_fr); end
    for (int c = 1; c < NS; c++) begin
      n_chk++;
      if (fr[c] !== '0) begin n_fail++; $display("FAIL px8410_chain%0d: got %h required 0", c, fr[c]); end
    end
  endtask

  task automatic test_red_pixel0();
    fill(16'h0000);
    for (int c = 0; c < NS; c++) mem[c*16] = 16'hF800;
    run_frame(1'b0);
    check_common("red");
    exp_fr = '0; exp_fr[15:0] = 16'hFFFF;
    for (int c = 0; c < NS; c++) begin
      n_chk++;
      if (fr[c] !== exp_fr) begin n_fail++; $display("FAIL red_chain%0d: got %h required %h", c, fr[c], exp_fr); end
    end
  endtask

  task automatic test_back_to_back();
    fill(16'hFFFF);
    run_frame(1'b1);
    check_common("restart_ignored");
  endtask

  task automatic test_random_buffer();
    for (int i = 0; i < RW; i++) mem[i] = 16'($urandom);
    run_frame(1'b0);
    check_common("rand");
    for (int c = 0; c < NS; c++) begin
      exp_fr = '0;
      for (int p = 15; p >= 0; p--) exp_fr = {exp_fr[FB-49:0], tb_expand(mem[c*16+p])};
      n_chk++;
      if (fr[c] !== exp_fr) begin n_fail++; $display("FAIL rand_chain%0d: got %h required %h", c, fr[c], exp_fr); end
    end
  endtask

  task automatic test_reset_midframe();
    int busy_seen = 0;
    fill(16'hFFFF);
    clear_stats();
    @(posedge spiClk); #1 cmdStart = 1'b1;
    @(posedge spiClk); #1 cmdStart = 1'b0;
    for (int k = 0; k < 3000 && rises < 400; k++) begin @(negedge spiClk); sample(); end
    n_chk++;
    if (rises != 400) begin n_fail++; $display("FAIL midreset_reach_bit400: got %0d rises required 400", rises); end
    nReset = 1'b0;
    @(negedge spiClk);
    n_chk++;
    if ({busy, cmdDone, LAT, SCLK, SDOs, rdaddress} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b required 0", {busy, cmdDone, LAT, SCLK, SDOs, rdaddress});
    end
    @(negedge spiClk);
    nReset = 1'b1;
    clear_stats();
    for (int k = 0; k < 60; k++) begin @(negedge spiClk); sample(); if (busy) busy_seen++; end
    n_chk++;
    if (lat_pulses != 0 || dones != 0 || busy_seen != 0 || rises != 0) begin
      n_fail++;
      $display("FAIL midreset_abort: lat %0d done %0d busy %0d sclk %0d required all 0", lat_pulses, dones, busy_seen, rises);
    end
    run_frame(1'b0);
    check_common("after_reset");
    exp_fr = '1; exp_fr[FB-1] = 1'b0;
    for (int c = 0; c < NS; c++) begin
      n_chk++;
      if (fr[c] !== exp_fr) begin n_fail++; $display("FAIL after_reset_chain%0d: got %h required %h", c, fr[c], exp_fr); end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_pixel();
    test_red_pixel0();
    test_back_to_back();
    test_random_buffer();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
